// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: drives NextPC, issues req/ack reads and hands instructions to decode.
// Define FETCH_TIMEOUT_EN to add an ack watchdog with a sticky FetchErr and automatic request re-issue.
module fetch_sequencer #(
  parameter int unsigned AW = 8,
  parameter int unsigned IW = 16
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 15
`endif
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic [AW-1:0] CurrentPC,
  output logic [AW-1:0] NextPC,
  output logic          IMemReq,
  output logic [AW-1:0] IMemAddr,
  input  logic          IMemAck,
  input  logic [IW-1:0] IMemData,
  output logic [IW-1:0] Instr,
  output logic          InstrValid,
  input  logic          InstrReady,
  input  logic          BranchTaken,
  input  logic [AW-1:0] BranchTarget,
  output logic          FetchErr
);

  typedef enum logic [2:0] {IDLE, FETCH, FLUSH, ISSUE, RETRY} state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] next_pc;
  logic          enter_fetch;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          stall_c;

  // A live request with no ack this cycle; a branch out of FETCH restarts the count via FLUSH entry.
  assign stall_c = req_q && !IMemAck &&
                   ((state_q == FETCH && !BranchTaken) || state_q == FLUSH);
`endif

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    next_pc     = CurrentPC;
    enter_fetch = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d       = '0;
    err_d       = err_q;
`endif
    unique case (state_q)
      IDLE: enter_fetch = 1'b1;
      FETCH: begin
        if (IMemAck && BranchTaken) begin
          next_pc     = BranchTarget;
          enter_fetch = 1'b1;
        end else if (IMemAck) begin
          instr_d = IMemData;
          valid_d = 1'b1;
          next_pc = CurrentPC + AW'(1);
          req_d   = 1'b0;
          state_d = ISSUE;
        end else if (BranchTaken) begin
          next_pc = BranchTarget;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Stale data is dropped; the PC already holds the newest target.
        if (BranchTaken) next_pc = BranchTarget;
        if (IMemAck) enter_fetch = 1'b1;
      end
      ISSUE: begin
        if (BranchTaken) begin
          next_pc     = BranchTarget;
          valid_d     = 1'b0;
          enter_fetch = 1'b1;
        end else if (InstrReady) begin
          valid_d     = 1'b0;
          enter_fetch = 1'b1;
        end
      end
      RETRY: begin
        if (BranchTaken) next_pc = BranchTarget;
        enter_fetch = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (enter_fetch) begin
      state_d = FETCH;
      req_d   = 1'b1;
      addr_d  = next_pc;
    end

`ifdef FETCH_TIMEOUT_EN
    if (stall_c) begin
      if (cnt_q == CW'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        req_d   = 1'b0;
        state_d = RETRY;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign NextPC     = next_pc;
  assign IMemReq    = req_q;
  assign IMemAddr   = addr_q;
  assign Instr      = instr_q;
  assign InstrValid = valid_q;
`ifdef FETCH_TIMEOUT_EN
  assign FetchErr   = err_q;
`else
  assign FetchErr   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: PC register and latency-programmable memory around the DUT,
// directed scenarios plus randomized traffic against an instruction-stream scoreboard.
module tb_fetch_sequencer;
  localparam int unsigned AW = 8;
  localparam int unsigned IW = 16;

  logic          CLK = 1'b0;
  logic          Reset_n = 1'b0;
  logic [AW-1:0] CurrentPC = '0;
  logic [AW-1:0] NextPC;
  logic          IMemReq;
  logic [AW-1:0] IMemAddr;
  logic          IMemAck = 1'b0;
  logic [IW-1:0] IMemData = '0;
  logic [IW-1:0] Instr;
  logic          InstrValid;
  logic          InstrReady = 1'b0;
  logic          BranchTaken = 1'b0;
  logic [AW-1:0] BranchTarget = '0;
  logic          FetchErr;

  fetch_sequencer dut (
    .CLK(CLK), .Reset_n(Reset_n), .CurrentPC(CurrentPC), .NextPC(NextPC),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
    .Instr(Instr), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .FetchErr(FetchErr)
  );

  always #5 CLK = ~CLK;

  logic [IW-1:0] mem [256];
  int total = 0;
  int bad = 0;
  int n_acc = 0;

  // Snapshot of one cycle, taken mid-cycle
  logic          o_req, o_valid, o_ack, o_err, o_req_rise;
  logic [AW-1:0] o_addr, o_next, o_pc;
  logic [IW-1:0] o_instr;
  logic          prev_req = 1'b0, prev_valid = 1'b0;
  logic [AW-1:0] nxt, exp_pc = '0;

  // Memory responder state
  logic          m_busy = 1'b0;
  logic [AW-1:0] m_addr = '0;
  int            m_wait = 0, m_lat = 1;
  int            mem_lat = 1;
  logic          rand_lat = 1'b0, mem_never = 1'b0, spurious = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Ack arrives m_lat cycles after the first cycle a request is seen at a given address.
  task automatic mem_respond();
    IMemAck  = 1'b0;
    IMemData = 16'($urandom);
    if (!Reset_n || !IMemReq) begin
      m_busy = 1'b0;
      if (Reset_n && spurious && $urandom_range(0, 9) == 0) IMemAck = 1'b1;
    end else begin
      if (!m_busy || IMemAddr != m_addr) begin
        m_busy = 1'b1;
        m_addr = IMemAddr;
        m_wait = 0;
        m_lat  = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
      end else begin
        m_wait++;
      end
      if (!mem_never && m_wait == m_lat) begin
        IMemAck  = 1'b1;
        IMemData = mem[m_addr];
        m_busy   = 1'b0;
      end
    end
  endtask

  // One clock: drive inputs, observe mid-cycle, update scoreboard, then PC register and memory.
  task automatic run_cycle(input logic br, input logic [AW-1:0] tgt, input logic rdy);
    BranchTaken  = br;
    BranchTarget = tgt;
    InstrReady   = rdy;
    @(negedge CLK);
    o_req   = IMemReq;  o_addr = IMemAddr; o_valid = InstrValid; o_instr = Instr;
    o_next  = NextPC;   o_pc   = CurrentPC; o_ack  = IMemAck;   o_err   = FetchErr;
    o_req_rise = o_req && !prev_req;
    if (Reset_n) begin
      if (br) begin
        exp_pc = tgt;
      end else if (o_valid && rdy) begin
        chk("instr_data", 32'(o_instr), 32'(mem[exp_pc]));
        exp_pc = exp_pc + 8'd1;
        n_acc++;
      end
      if (o_valid && !prev_valid) chk("req_drop_after_ack", 32'(o_req), 32'd0);
    end
    prev_req   = o_req;
    prev_valid = o_valid;
    nxt = NextPC;
    @(posedge CLK);
    #1;
    CurrentPC = Reset_n ? nxt : '0;
    mem_respond();
  endtask

  initial begin
    int            n_valid, nv, acc0;
    logic [AW-1:0] exp_fa, hold_pc, a;
    logic [IW-1:0] hold_i;
    logic          hit, saw_ack;

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

    // Reset values
    for (int k = 0; k < 3; k++) run_cycle(1'b0, '0, 1'b0);
    chk("rst_req", 32'(o_req), 32'd0);
    chk("rst_addr", 32'(o_addr), 32'd0);
    chk("rst_instr", 32'(o_instr), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    Reset_n = 1'b1;

    // Sequential fetch with 1-cycle memory
    mem_lat = 1;
    n_valid = 0;
    exp_fa  = '0;
    for (int k = 0; k < 12; k++) begin
      run_cycle(1'b0, '0, 1'b1);
      if (o_req_rise) begin
        chk("seq_fetch_addr", 32'(o_addr), 32'(exp_fa));
        exp_fa = exp_fa + 8'd1;
      end
      if (o_valid) n_valid++;
      if (o_req && o_ack) chk("seq_nextpc_adv", 32'(o_next), 32'(o_pc + 8'd1));
    end
    chk("seq_valid_count", 32'(n_valid), 32'd3);
    chk("seq_fetch_count", 32'(exp_fa), 32'd4);

    // PC wrap 0xFF -> 0x00
    for (int k = 0; k < 10 && !InstrValid; k++) run_cycle(1'b0, '0, 1'b1);
    run_cycle(1'b1, 8'hFF, 1'b1);
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      run_cycle(1'b0, '0, 1'b1);
      if (o_req && o_ack) begin
        hit = 1'b1;
        chk("wrap_pc", 32'(o_pc), 32'hFF);
        chk("wrap_nextpc", 32'(o_next), 32'h00);
      end
    end
    chk("wrap_ack_seen", 32'(hit), 32'd1);
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      run_cycle(1'b0, '0, 1'b1);
      hit = o_req_rise;
    end
    chk("wrap_fetch_addr", 32'({hit, o_addr}), 32'({1'b1, 8'h00}));

    // Decoder stall in ISSUE
    for (int k = 0; k < 20 && !InstrValid; k++) run_cycle(1'b0, '0, 1'b0);
    chk("stall_reach_issue", 32'(InstrValid), 32'd1);
    hold_i  = Instr;
    hold_pc = CurrentPC;
    for (int k = 0; k < 5; k++) begin
      run_cycle(1'b0, '0, 1'b0);
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_instr", 32'(o_instr), 32'(hold_i));
      chk("stall_req", 32'(o_req), 32'd0);
      chk("stall_nextpc", 32'(o_next), 32'(o_pc));
    end
    run_cycle(1'b0, '0, 1'b1);
    run_cycle(1'b0, '0, 1'b1);
    chk("stall_refetch", 32'({o_req, o_addr}), 32'({1'b1, hold_pc}));

    // Branch during a 3-cycle fetch: FLUSH, stale data never presented
    mem_lat = 3;
    for (int k = 0; k < 20 && !InstrValid; k++) run_cycle(1'b0, '0, 1'b0);
    run_cycle(1'b1, 8'h10, 1'b0);
    run_cycle(1'b0, '0, 1'b1);
    chk("flush_src_addr", 32'({o_req, o_addr}), 32'({1'b1, 8'h10}));
    run_cycle(1'b1, 8'h40, 1'b1);
    nv = 0;
    saw_ack = 1'b0;
    for (int k = 0; k < 10; k++) begin
      run_cycle(1'b0, '0, 1'b1);
      if (o_valid) nv++;
      if (o_ack) saw_ack = 1'b1;
      if (o_addr != 8'h10) break;
    end
    chk("flush_ack_seen", 32'(saw_ack), 32'd1);
    chk("flush_no_valid", 32'(nv), 32'd0);
    chk("flush_new_addr", 32'({o_req, o_addr}), 32'({1'b1, 8'h40}));

    // Branch in the same cycle as the ack
    hit = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (IMemAck) begin
        run_cycle(1'b1, 8'h20, 1'b1);
        hit = 1'b1;
        break;
      end
      run_cycle(1'b0, '0, 1'b1);
    end
    chk("ackbr_hit", 32'(hit), 32'd1);
    run_cycle(1'b0, '0, 1'b1);
    chk("ackbr_valid", 32'(o_valid), 32'd0);
    chk("ackbr_addr", 32'({o_req, o_addr}), 32'({1'b1, 8'h20}));

    // Branch in ISSUE overrides InstrReady
    for (int k = 0; k < 10 && !InstrValid; k++) run_cycle(1'b0, '0, 1'b0);
    run_cycle(1'b0, '0, 1'b1);
    hit = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (InstrValid) begin
        run_cycle(1'b1, 8'h20, 1'b1);
        hit = 1'b1;
        break;
      end
      run_cycle(1'b0, '0, 1'b1);
    end
    chk("issuebr_hit", 32'(hit), 32'd1);
    run_cycle(1'b0, '0, 1'b1);
    chk("issuebr_valid", 32'(o_valid), 32'd0);
    chk("issuebr_addr", 32'({o_req_rise, o_addr}), 32'({1'b1, 8'h20}));

    // Randomized traffic
    rand_lat = 1'b1;
    spurious = 1'b1;
    acc0 = n_acc;
    for (int k = 0; k < 1500; k++) begin
      run_cycle(($urandom_range(0, 19) == 0), 8'($urandom), ($urandom_range(0, 3) != 0));
    end
    chk("rand_progress", 32'(n_acc - acc0 > 50), 32'd1);
    rand_lat = 1'b0;
    spurious = 1'b0;
    mem_lat  = 1;

`ifdef FETCH_TIMEOUT_EN
    // Ack never arrives: watchdog fires, drops the request for one cycle, re-issues same address
    for (int k = 0; k < 50 && !InstrValid; k++) run_cycle(1'b0, '0, 1'b0);
    chk("to_reach_issue", 32'(InstrValid), 32'd1);
    mem_never = 1'b1;
    run_cycle(1'b0, '0, 1'b1);
    run_cycle(1'b0, '0, 1'b1);
    a = o_addr;
    chk("to_req_start", 32'(o_req), 32'd1);
    for (int k = 1; k < 15; k++) run_cycle(1'b0, '0, 1'b1);
    chk("to_err_before", 32'({o_err, o_req}), 32'({1'b0, 1'b1}));
    run_cycle(1'b0, '0, 1'b1);
    chk("to_err_set", 32'(o_err), 32'd1);
    chk("to_req_gap", 32'(o_req), 32'd0);
    chk("to_nextpc_hold", 32'(o_next), 32'(a));
    run_cycle(1'b0, '0, 1'b1);
    chk("to_rerequest", 32'({o_req, o_addr}), 32'({1'b1, a}));
    mem_never = 1'b0;
    for (int k = 0; k < 10 && !InstrValid; k++) run_cycle(1'b0, '0, 1'b1);
    run_cycle(1'b0, '0, 1'b1);
    chk("to_completes", 32'({o_valid, o_instr}), 32'({1'b1, mem[a]}));
    chk("to_err_sticky", 32'(o_err), 32'd1);
`else
    chk("no_err_default", 32'(o_err), 32'd0);
`endif

    // Asynchronous reset mid-operation
    for (int k = 0; k < 3; k++) run_cycle(1'b0, '0, 1'b1);
    Reset_n = 1'b0;
    #2;
    chk("rst2_outputs", 32'({IMemReq, InstrValid, FetchErr}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch front end that drives the program counter register's NextPC input and fetches from instruction memory.
- Issues a req/ack read to instruction memory at the current PC and hands the instruction to the decoder over a valid/ready handshake.
- Advances the PC by one, or redirects it on a taken branch; discards in-flight fetches on redirect.
- Sits between the 8-bit PC register, the instruction memory and the decode stage.

Parameters:
- AW, 8, PC and instruction-address width in bits.
- IW, 16, instruction width in bits.
- TIMEOUT, 15, max cycles waiting for IMemAck before an error. Used only with the optional feature.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- CurrentPC  input  AW  PC register output.
- NextPC  output  AW  PC register input; PC loads it every cycle.
- IMemReq  output  1  fetch request, level.
- IMemAddr  output  AW  fetch address, registered.
- IMemAck  input  1  one-cycle pulse; IMemData valid this cycle.
- IMemData  input  IW  fetched instruction.
- Instr  output  IW  instruction to decoder.
- InstrValid  output  1  Instr valid.
- InstrReady  input  1  decoder accepts Instr.
- BranchTaken  input  1  one-cycle redirect pulse from execute.
- BranchTarget  input  AW  redirect address.
- FetchErr  output  1  sticky timeout flag. Driven 0 unless FETCH_TIMEOUT_EN is defined.

Behaviour:
- Reset (Reset_n=0, asynchronous): state=IDLE, IMemReq=0, IMemAddr=0, Instr=0, InstrValid=0, FetchErr=0.
- NextPC is combinational. It equals CurrentPC unless an advance or redirect occurs that cycle, so the PC holds by reloading itself.
- Every transition into FETCH registers IMemAddr<=NextPC. The address stays stable for the whole request.
- IDLE: for the first cycle after reset release, go to FETCH.
- FETCH: IMemReq=1.
  - On IMemAck without BranchTaken: Instr<=IMemData, InstrValid<=1, NextPC=CurrentPC+1 (mod 2^AW, 8'hFF->8'h00), go to ISSUE.
  - On BranchTaken without IMemAck: NextPC=BranchTarget, go to FLUSH.
  - On BranchTaken and IMemAck together: discard data, NextPC=BranchTarget, go to FETCH (new address).
- FLUSH: IMemReq=1, IMemAddr unchanged.
  - Wait for IMemAck, discard the data, go to FETCH.
  - BranchTaken in FLUSH: NextPC=BranchTarget; the latest target wins.
- ISSUE: InstrValid=1, IMemReq=0, Instr stable.
  - BranchTaken (priority over InstrReady): InstrValid<=0, NextPC=BranchTarget, go to FETCH.
  - Else InstrReady: InstrValid<=0, go to FETCH.
  - Else hold.
- IMemReq drops the cycle after an accepted ack, and is low for at least one cycle between requests.
- Throughput: one instruction per (memory latency + 2) cycles with InstrReady held high.
- IMemAck while IMemReq=0 is ignored.
- Reset asserted mid-fetch abandons the request immediately. The memory must tolerate IMemReq dropping.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entering FETCH/FLUSH and increments each cycle without IMemAck.
  - When it reaches TIMEOUT, FetchErr<=1 (sticky until reset) and the request is re-issued: IMemReq low for 1 cycle, then FETCH at the same IMemAddr.
  - The PC is unchanged.
- Undefined: no counter; FetchErr tied to 0; the request waits indefinitely.

Test Plan:
- Reset release, 1-cycle memory ack, InstrReady=1 → requests at 0x00, 0x01, 0x02. Instr matches memory. One InstrValid pulse per 3 cycles. NextPC increments on each ack cycle.
- CurrentPC=0xFF, ack → NextPC=0x00; next IMemAddr=0x00.
- InstrReady=0 for 5 cycles in ISSUE → InstrValid and Instr held, IMemReq=0, NextPC=CurrentPC; on ready, fetch at CurrentPC.
- BranchTaken, target 0x40, while FETCH at 0x10 with 3-cycle latency → FLUSH. Ack data at 0x10 never shows InstrValid. Next IMemAddr=0x40.
- BranchTaken, target 0x20, same cycle as ack, and separately in ISSUE with InstrReady=1 → data dropped, InstrValid=0, next IMemAddr=0x20 in both cases.
- FETCH_TIMEOUT_EN defined, TIMEOUT=15, no ack → FetchErr=1 after 15 cycles. IMemReq low 1 cycle, then re-request at the same address. Later ack completes normally; FetchErr stays 1 until Reset_n=0.
